// File: rtl/simon_pkg.sv
// simon_pkg: shared constants and types for the Simon round-key store.
// Per-variant word/depth/key-word triples select the store geometry.
package simon_pkg;

    // Simon <block>/<key>: word width, round-key count, master-key words
    localparam int SIMON64_96_WORD_W     = 32;
    localparam int SIMON64_96_DEPTH      = 42;
    localparam int SIMON64_96_KEY_WORDS  = 3;
    localparam int SIMON64_128_WORD_W    = 32;
    localparam int SIMON64_128_DEPTH     = 44;
    localparam int SIMON64_128_KEY_WORDS = 4;
    localparam int SIMON96_96_WORD_W     = 48;
    localparam int SIMON96_96_DEPTH      = 52;
    localparam int SIMON96_96_KEY_WORDS  = 2;
    localparam int SIMON96_144_WORD_W    = 48;
    localparam int SIMON96_144_DEPTH     = 54;
    localparam int SIMON96_144_KEY_WORDS = 3;
    localparam int SIMON128_128_WORD_W    = 64;
    localparam int SIMON128_128_DEPTH     = 68;
    localparam int SIMON128_128_KEY_WORDS = 2;
    localparam int SIMON128_192_WORD_W    = 64;
    localparam int SIMON128_192_DEPTH     = 69;
    localparam int SIMON128_192_KEY_WORDS = 3;
    localparam int SIMON128_256_WORD_W    = 64;
    localparam int SIMON128_256_DEPTH     = 72;
    localparam int SIMON128_256_KEY_WORDS = 4;

    localparam int KS_WORD_W    = SIMON128_256_WORD_W;
    localparam int KS_DEPTH     = SIMON128_256_DEPTH;
    localparam int KS_KEY_WORDS = SIMON128_256_KEY_WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ks_state_t;

endpackage

// File: rtl/simon_sdp_ram.sv
// simon_sdp_ram: simple-dual-port RAM, read-first registered output.
// Only the output register is reset; the array keeps its contents.
module simon_sdp_ram #(
    parameter int W  = 64,
    parameter int D  = 72,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] rd_q;
    logic [W-1:0] rd_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    // rclr forces zero for reads outside the array
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = rclr ? '0 : mem_q[ra];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/simon_key_store.sv
// simon_key_store: round-key RAM with bulk master-key load,
// per-entry valid tracking, fill count and access-error pulse.
module simon_key_store
    import simon_pkg::*;
#(
    parameter int WORD_W    = KS_WORD_W,
    parameter int DEPTH     = KS_DEPTH,
    parameter int KEY_WORDS = KS_KEY_WORDS,
    parameter int AW        = $clog2(DEPTH),
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_load,
    input  logic [KEY_WORDS*WORD_W-1:0] key_in,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_adr,
    input  logic [WORD_W-1:0]           wr_data,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_adr,
    output logic [WORD_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        load_busy,
    output logic [CW-1:0]               fill_cnt,
    output logic                        full,
    output logic                        err
);

    localparam int LW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [LW-1:0] LC_LAST = LW'(KEY_WORDS - 1);

    ks_state_t         state_q, state_d;
    logic [LW-1:0]     lc_q, lc_d;
    logic [WORD_W-1:0] shadow_q [KEY_WORDS];
    logic [WORD_W-1:0] shadow_d [KEY_WORDS];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;

    logic              load_go;
    logic              wr_ok;
    logic              wr_in_rng;
    logic              rd_in_rng;
    logic              ram_we;
    logic [AW-1:0]     ram_wa;
    logic [WORD_W-1:0] ram_wd;

    assign wr_in_rng = {1'b0, wr_adr} < DEPTH_A;
    assign rd_in_rng = {1'b0, rd_adr} < DEPTH_A;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lc_q    <= '0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    state_d = LOAD;
                    lc_d    = '0;
                end
            end
            LOAD: begin
                lc_d = lc_q + 1'b1;
                if (lc_q == LC_LAST) begin
                    state_d = IDLE;
                    lc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                lc_d    = '0;
            end
        endcase
    end

    // LOAD owns the write port; external writes only land in IDLE
    always_comb begin
        load_go = 1'b0;
        wr_ok   = 1'b0;
        ram_we  = 1'b0;
        ram_wa  = wr_adr;
        ram_wd  = wr_data;
        unique case (state_q)
            IDLE: begin
                load_go = key_load;
                wr_ok   = wr_en && wr_in_rng && !key_load;
                ram_we  = wr_ok;
            end
            LOAD: begin
                ram_we = 1'b1;
                ram_wa = AW'(lc_q);
                ram_wd = shadow_q[lc_q];
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        fill_d   = fill_q;
        if (load_go) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                shadow_d[i] = key_in[i*WORD_W +: WORD_W];
            end
            valid_d = '0;
            fill_d  = '0;
        end else if (ram_we && !valid_q[ram_wa]) begin
            valid_d[ram_wa] = 1'b1;
            fill_d          = fill_q + 1'b1;
        end
        full_d = (fill_d == DEPTH_C);
        err_d  = (wr_en && (state_q == LOAD || key_load || !wr_in_rng))
               || (rd_en && !rd_in_rng);
        rd_valid_d = rd_en && rd_in_rng && valid_q[rd_adr];
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    simon_sdp_ram #(
        .W  (WORD_W),
        .D  (DEPTH),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .wa    (ram_wa),
        .wd    (ram_wd),
        .re    (rd_en),
        .rclr  (!rd_in_rng),
        .ra    (rd_adr),
        .rd    (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign load_busy = (state_q == LOAD);
    assign fill_cnt  = fill_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_simon_key_store.sv
// tb_simon_key_store: vector table plus scoreboarded reads on the
// default store, and a 32/44/3 instance for short-load and reset cases.
module tb_simon_key_store;

    logic         clk;
    logic         rst_n;
    logic         key_load;
    logic [255:0] key_in;
    logic         wr_en;
    logic [6:0]   wr_adr;
    logic [63:0]  wr_data;
    logic         rd_en;
    logic [6:0]   rd_adr;
    logic [63:0]  rd_data;
    logic         rd_valid;
    logic         load_busy;
    logic [6:0]   fill_cnt;
    logic         full;
    logic         err;

    logic         rst2_n;
    logic         key_load2;
    logic [95:0]  key_in2;
    logic         wr_en2;
    logic [5:0]   wr_adr2;
    logic [31:0]  wr_data2;
    logic         rd_en2;
    logic [5:0]   rd_adr2;
    logic [31:0]  rd_data2;
    logic         rd_valid2;
    logic         load_busy2;
    logic [5:0]   fill_cnt2;
    logic         full2;
    logic         err2;

    simon_key_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .wr_en     (wr_en),
        .wr_adr    (wr_adr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_adr    (rd_adr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .load_busy (load_busy),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .err       (err)
    );

    simon_key_store #(
        .WORD_W    (32),
        .DEPTH     (44),
        .KEY_WORDS (3)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .key_load  (key_load2),
        .key_in    (key_in2),
        .wr_en     (wr_en2),
        .wr_adr    (wr_adr2),
        .wr_data   (wr_data2),
        .rd_en     (rd_en2),
        .rd_adr    (rd_adr2),
        .rd_data   (rd_data2),
        .rd_valid  (rd_valid2),
        .load_busy (load_busy2),
        .fill_cnt  (fill_cnt2),
        .full      (full2),
        .err       (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] KEY = {64'h1f1e1d1c1b1a1918,
                                    64'h1716151413121110,
                                    64'h0f0e0d0c0b0a0908,
                                    64'h0706050403020100};
    localparam logic [95:0] KEY2 = {32'h0b0a0908, 32'h07060504,
                                    32'h03020100};

    typedef struct {
        logic        wr_en;
        logic [6:0]  wr_adr;
        logic [63:0] wr_data;
        logic        rd_en;
        logic [6:0]  rd_adr;
        logic        chk_d;
        logic [63:0] exp_d;
        logic        exp_v;
        logic [6:0]  exp_fill;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       nm;
        logic        chk_d;
        logic [63:0] d;
        logic        v;
    } sb_t;

    vec_t vt [9];
    sb_t  sbq [$];
    bit   sb_due;
    int   checks;
    int   errors;
    int   n;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_rd(input string nm, input logic chk_d,
                           input logic [63:0] d, input logic v);
        sb_t e;
        e.nm    = nm;
        e.chk_d = chk_d;
        e.d     = d;
        e.v     = v;
        sbq.push_back(e);
        sb_due = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sb_due) begin
            sb_t e;
            e = sbq.pop_front();
            if (e.chk_d) check({e.nm, "_data"}, rd_data, e.d);
            check({e.nm, "_valid"}, {63'd0, rd_valid}, {63'd0, e.v});
            sb_due = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sb_due = 1'b0;

        vt[0] = '{1'b1, 7'd10, 64'hAA, 1'b0, 7'd0,
                  1'b0, 64'h0, 1'b0, 7'd72, 1'b0};
        vt[1] = '{1'b0, 7'd0, 64'h0, 1'b1, 7'd10,
                  1'b1, 64'hAA, 1'b1, 7'd72, 1'b0};
        vt[2] = '{1'b0, 7'd0, 64'h0, 1'b1, 7'd71,
                  1'b1, 64'd71, 1'b1, 7'd72, 1'b0};
        vt[3] = '{1'b1, 7'd72, 64'h5, 1'b1, 7'd100,
                  1'b1, 64'h0, 1'b0, 7'd72, 1'b1};
        vt[4] = '{1'b1, 7'd7, 64'h11, 1'b0, 7'd0,
                  1'b1, 64'h0, 1'b0, 7'd72, 1'b0};
        vt[5] = '{1'b1, 7'd7, 64'h22, 1'b1, 7'd7,
                  1'b1, 64'h11, 1'b1, 7'd72, 1'b0};
        vt[6] = '{1'b0, 7'd0, 64'h0, 1'b1, 7'd7,
                  1'b1, 64'h22, 1'b1, 7'd72, 1'b0};
        vt[7] = '{1'b0, 7'd0, 64'h0, 1'b1, 7'd4,
                  1'b1, 64'd4, 1'b1, 7'd72, 1'b0};
        vt[8] = '{1'b0, 7'd0, 64'h0, 1'b0, 7'd0,
                  1'b1, 64'd4, 1'b0, 7'd72, 1'b0};

        rst_n = 1'b0; key_load = 1'b0; key_in = '0;
        wr_en = 1'b0; wr_adr = '0; wr_data = '0;
        rd_en = 1'b0; rd_adr = '0;
        rst2_n = 1'b0; key_load2 = 1'b0; key_in2 = '0;
        wr_en2 = 1'b0; wr_adr2 = '0; wr_data2 = '0;
        rd_en2 = 1'b0; rd_adr2 = '0;
        tick();
        tick();
        check("rst_rd_data", rd_data, 64'h0);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_busy", {63'd0, load_busy}, 64'd0);
        check("rst_fill", {57'd0, fill_cnt}, 64'd0);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        tick();

        key_in = KEY;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("ld_fill0", {57'd0, fill_cnt}, 64'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!load_busy) break;
            n++;
            tick();
        end
        check("ld_busy_len", 64'(n), 64'd4);
        check("ld_fill4", {57'd0, fill_cnt}, 64'd4);

        rd_en = 1'b1;
        rd_adr = 7'd0;
        push_rd("rd_a0", 1'b1, 64'h0706050403020100, 1'b1);
        tick();
        rd_adr = 7'd3;
        push_rd("rd_a3", 1'b1, 64'h1f1e1d1c1b1a1918, 1'b1);
        tick();
        rd_adr = 7'd50;
        push_rd("rd_a50", 1'b0, 64'h0, 1'b0);
        tick();
        rd_en = 1'b0;

        wr_en = 1'b1;
        for (int a = 4; a < 72; a++) begin
            wr_adr = 7'(a);
            wr_data = 64'(a);
            tick();
            if (a == 70) begin
                check("fill_71", {57'd0, fill_cnt}, 64'd71);
                check("full_early", {63'd0, full}, 64'd0);
            end
        end
        wr_en = 1'b0;
        check("fill_72", {57'd0, fill_cnt}, 64'd72);
        check("full_set", {63'd0, full}, 64'd1);

        for (int i = 0; i < 9; i++) begin
            wr_en   = vt[i].wr_en;
            wr_adr  = vt[i].wr_adr;
            wr_data = vt[i].wr_data;
            rd_en   = vt[i].rd_en;
            rd_adr  = vt[i].rd_adr;
            push_rd($sformatf("vec%0d", i), vt[i].chk_d,
                    vt[i].exp_d, vt[i].exp_v);
            tick();
            check($sformatf("vec%0d_fill", i), {57'd0, fill_cnt},
                  {57'd0, vt[i].exp_fill});
            check($sformatf("vec%0d_err", i), {63'd0, err},
                  {63'd0, vt[i].exp_err});
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        key_load = 1'b1;
        wr_en = 1'b1;
        wr_adr = 7'd6;
        wr_data = 64'hdead;
        tick();
        check("col_busy0", {63'd0, load_busy}, 64'd1);
        check("col_err_kl", {63'd0, err}, 64'd1);
        check("col_fill0", {57'd0, fill_cnt}, 64'd0);
        wr_adr = 7'd5;
        tick();
        key_load = 1'b0;
        wr_en = 1'b0;
        check("col_err_load", {63'd0, err}, 64'd1);
        check("col_busy1", {63'd0, load_busy}, 64'd1);
        tick();
        check("col_err_ign", {63'd0, err}, 64'd0);
        check("col_busy2", {63'd0, load_busy}, 64'd1);
        tick();
        check("col_busy3", {63'd0, load_busy}, 64'd1);
        tick();
        check("col_busy4", {63'd0, load_busy}, 64'd0);
        check("col_fill4", {57'd0, fill_cnt}, 64'd4);
        check("col_full", {63'd0, full}, 64'd0);

        rd_en = 1'b1;
        rd_adr = 7'd5;
        push_rd("col_a5", 1'b1, 64'd5, 1'b0);
        tick();
        rd_adr = 7'd6;
        push_rd("col_a6", 1'b1, 64'd6, 1'b0);
        tick();
        rd_adr = 7'd0;
        push_rd("col_a0", 1'b1, 64'h0706050403020100, 1'b1);
        tick();
        rd_en = 1'b0;
        check("sb_empty", 64'(sbq.size()), 64'd0);

        key_in2 = KEY2;
        key_load2 = 1'b1;
        tick();
        key_load2 = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!load_busy2) break;
            n++;
            tick();
        end
        check("d2_busy_len", 64'(n), 64'd3);
        check("d2_fill3", {58'd0, fill_cnt2}, 64'd3);
        rd_en2 = 1'b1;
        rd_adr2 = 6'd2;
        tick();
        rd_en2 = 1'b0;
        check("d2_a2_data", {32'd0, rd_data2}, 64'h0b0a0908);
        check("d2_a2_valid", {63'd0, rd_valid2}, 64'd1);

        wr_en2 = 1'b1;
        wr_adr2 = 6'd44;
        wr_data2 = 32'h1234;
        tick();
        wr_en2 = 1'b0;
        check("d2_oor_err", {63'd0, err2}, 64'd1);
        check("d2_oor_fill", {58'd0, fill_cnt2}, 64'd3);
        tick();
        check("d2_err_pulse", {63'd0, err2}, 64'd0);

        key_load2 = 1'b1;
        tick();
        key_load2 = 1'b0;
        tick();
        tick();
        check("d2_mid_fill", {58'd0, fill_cnt2}, 64'd2);
        check("d2_mid_busy", {63'd0, load_busy2}, 64'd1);
        rst2_n = 1'b0;
        tick();
        check("d2_rst_fill", {58'd0, fill_cnt2}, 64'd0);
        check("d2_rst_busy", {63'd0, load_busy2}, 64'd0);
        check("d2_rst_full", {63'd0, full2}, 64'd0);
        check("d2_rst_err", {63'd0, err2}, 64'd0);
        check("d2_rst_rv", {63'd0, rd_valid2}, 64'd0);
        check("d2_rst_rd", {32'd0, rd_data2}, 64'd0);
        rst2_n = 1'b1;
        tick();
        check("d2_post_busy", {63'd0, load_busy2}, 64'd0);
        check("d2_post_fill", {58'd0, fill_cnt2}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
